fetch_stage: RTL and testbench

- Instruction fetch stage of the ARM-subset pipelined processor: owns PCF, issues requests to instruction memory, and loads the IF/ID register (InstD, PCPlus8D) that feeds the Decode stage.
- Producer end of the Decode input interface. Obeys StallF/StallD/FlushD from the hazard unit and redirects from Execute (branch) and Writeback (PC write).
- Single outstanding instruction-memory request.
- One-entry skid buffer absorbs a response that arrives while Decode is stalled.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_stage_if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch stage
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int PC_INC       = 4;
  localparam int PC_R15_OFS   = 8;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with flush > stall > load priority
// Revision  : 1.0
// ============================================================================
`default_nettype none

module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              load,
  input  logic [31:0]       inst_in,
  input  logic [ADDR_W-1:0] pcplus8_in,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pcplus8,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      inst    <= 32'd0;
      pcplus8 <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      inst  <= 32'd0;
      valid <= 1'b0;
    end else if (!(stall && valid)) begin
      if (load) begin
        inst    <= inst_in;
        pcplus8 <= pcplus8_in;
        valid   <= 1'b1;
      end else begin
        // Decode consumed the entry and nothing replaced it: present a bubble
        valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC owner, single-outstanding imem requester, IF/ID producer
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              BranchTakenE,
  input  logic [ADDR_W-1:0] BranchTargetE,
  input  logic              PCSrcW,
  input  logic [ADDR_W-1:0] ResultW,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       InstD,
  output logic [ADDR_W-1:0] PCPlus8D,
  output logic              ValidD,
  output logic [ADDR_W-1:0] PCF
);

  localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] c_pc_inc     = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] c_r15_ofs    = ADDR_W'(PC_R15_OFS);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pcf;
  logic [ADDR_W-1:0] r_skid_pc;
  logic [31:0]       r_skid_inst;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic              w_free;
  logic              w_rsp;
  logic              w_chain;
  logic              w_drain;
  logic              w_load;
  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_skid_seq;
  logic [31:0]       w_load_inst;
  logic [ADDR_W-1:0] w_load_pc8;

  assign w_redirect = BranchTakenE | PCSrcW;
  assign w_target   = (BranchTakenE ? BranchTargetE : ResultW) & c_align_mask;
  assign w_free     = !ValidD || !StallD;
  assign w_rsp      = (r_state == WAIT) && imem_rvalid && !w_redirect;
  assign w_chain    = w_rsp && w_free;
  assign w_drain    = (r_state == HOLD) && !StallD && !w_redirect;
  assign w_load     = w_chain || w_drain;
  assign w_pc_seq   = (r_pcf + c_pc_inc) & c_align_mask;
  assign w_skid_seq = (r_skid_pc + c_pc_inc) & c_align_mask;

  assign w_load_inst = w_drain ? r_skid_inst : imem_rdata;
  assign w_load_pc8  = (w_drain ? r_skid_pc : r_pcf) + c_r15_ofs;

  assign PCF = r_pcf;

  // A chained request targets the word after the one landing this cycle
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pcf;
    if (reset) begin
      case (r_state)
        REQ:  imem_req = !StallF && !w_redirect;
        WAIT: begin
          if (w_chain) begin
            imem_req  = !StallF;
            imem_addr = w_pc_seq;
          end
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= REQ;
      r_pcf       <= RESET_PC & c_align_mask;
      r_skid_pc   <= '0;
      r_skid_inst <= 32'd0;
    end else if (w_redirect) begin
      r_pcf <= w_target;
      // An outstanding response not yet returned must be swallowed later
      if ((r_state == WAIT || r_state == DROP) && !imem_rvalid)
        r_state <= DROP;
      else
        r_state <= REQ;
    end else begin
      case (r_state)
        REQ: begin
          if (imem_req && imem_ready)
            r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (w_free) begin
              r_pcf   <= w_pc_seq;
              r_state <= (imem_req && imem_ready) ? WAIT : REQ;
            end else begin
              r_skid_inst <= imem_rdata;
              r_skid_pc   <= r_pcf;
              r_state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!StallD) begin
            r_pcf   <= w_skid_seq;
            r_state <= REQ;
          end
        end
        DROP: begin
          if (imem_rvalid)
            r_state <= REQ;
        end
        default: r_state <= REQ;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .stall      (StallD),
    .flush      (FlushD | w_redirect),
    .load       (w_load),
    .inst_in    (w_load_inst),
    .pcplus8_in (w_load_pc8),
    .inst       (InstD),
    .pcplus8    (PCPlus8D),
    .valid      (ValidD)
  );

  a_rvalid_only_when_outstanding : assert property (
    @(posedge clk) disable iff (!reset)
    imem_rvalid |-> (r_state == WAIT || r_state == DROP)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD;
  logic        BranchTakenE, PCSrcW;
  logic [31:0] BranchTargetE, ResultW;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstD, PCPlus8D, PCF;
  logic        ValidD;

  int checks = 0;
  int failures = 0;

  // Memory model: returns the word address as data after mem_lat cycles
  int          mem_lat;
  int          m_cnt;
  logic        m_pend;
  logic        m_overlap;
  logic [31:0] m_addr;

  assign imem_ready  = 1'b1;
  assign imem_rvalid = m_pend && (m_cnt == 0);
  assign imem_rdata  = m_addr;

  always @(posedge clk) begin
    if (!reset) begin
      m_pend    <= 1'b0;
      m_overlap <= 1'b0;
      m_cnt     <= 0;
      m_addr    <= 32'd0;
    end else if (imem_req && imem_ready) begin
      if (m_pend && !imem_rvalid) m_overlap <= 1'b1;
      m_pend <= 1'b1;
      m_addr <= imem_addr;
      m_cnt  <= mem_lat - 1;
    end else if (imem_rvalid) begin
      m_pend <= 1'b0;
    end else if (m_pend) begin
      m_cnt <= m_cnt - 1;
    end
  end

  fetch_stage #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .PCSrcW        (PCSrcW),
    .ResultW       (ResultW),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .InstD         (InstD),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD),
    .PCF           (PCF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset(input int lat);
    @(negedge clk);
    reset = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; PCSrcW = 1'b0;
    BranchTargetE = 32'd0; ResultW = 32'd0;
    mem_lat = lat;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    BranchTakenE = 1'b0; PCSrcW = 1'b0;
    BranchTargetE = 32'd0; ResultW = 32'd0;
    mem_lat = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL reset_pcf: got %h want %h", PCF, 32'h0); end
    checks++; if (InstD !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h want %h", InstD, 32'h0); end
    checks++; if (PCPlus8D !== 32'h0) begin failures++; $display("FAIL reset_pc8: got %h want %h", PCPlus8D, 32'h0); end
    checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", ValidD); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
  endtask

  task automatic test_stream();
    apply_reset(1);
    for (int k = 0; k < 5; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin
        failures++; $display("FAIL stream_req[%0d]: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4*k)); end
      if (k >= 2) begin
        checks++; if (ValidD !== 1'b1 || InstD !== 32'(4*(k-2)) || PCPlus8D !== 32'(4*(k-2)+8)) begin
          failures++; $display("FAIL stream_ifid[%0d]: got v=%b inst=%h pc8=%h want v=1 inst=%h pc8=%h",
                               k, ValidD, InstD, PCPlus8D, 32'(4*(k-2)), 32'(4*(k-2)+8)); end
      end else begin
        checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL stream_valid[%0d]: got %b want 0", k, ValidD); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_skid();
    apply_reset(1);
    repeat (6) @(negedge clk);
    checks++; if (InstD !== 32'h10 || ValidD !== 1'b1) begin
      failures++; $display("FAIL stall_pre: got inst=%h v=%b want inst=00000010 v=1", InstD, ValidD); end
    StallD = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_nochain: got req=%b want 0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (InstD !== 32'h10 || ValidD !== 1'b1 || imem_req !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d]: got inst=%h v=%b req=%b want inst=00000010 v=1 req=0", i, InstD, ValidD, imem_req); end
    end
    StallD = 1'b0;
    @(negedge clk);
    checks++; if (InstD !== 32'h14 || PCPlus8D !== 32'h1C || ValidD !== 1'b1) begin
      failures++; $display("FAIL stall_skid_out: got inst=%h pc8=%h v=%b want inst=00000014 pc8=0000001c v=1", InstD, PCPlus8D, ValidD); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin
      failures++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=00000018", imem_req, imem_addr); end
  endtask

  task automatic test_branch();
    apply_reset(1);
    repeat (4) @(negedge clk);
    checks++; if (InstD !== 32'h8 || ValidD !== 1'b1) begin
      failures++; $display("FAIL branch_pre: got inst=%h v=%b want inst=00000008 v=1", InstD, ValidD); end
    BranchTakenE = 1'b1; BranchTargetE = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL branch_noreq: got req=%b want 0", imem_req); end
    @(negedge clk);
    BranchTakenE = 1'b0;
    #1;
    checks++; if (ValidD !== 1'b0 || InstD !== 32'h0 || PCPlus8D !== 32'h10) begin
      failures++; $display("FAIL branch_flush: got v=%b inst=%h pc8=%h want v=0 inst=00000000 pc8=00000010", ValidD, InstD, PCPlus8D); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL branch_target: got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (InstD !== 32'h100 || PCPlus8D !== 32'h108 || ValidD !== 1'b1) begin
      failures++; $display("FAIL branch_load: got inst=%h pc8=%h v=%b want inst=00000100 pc8=00000108 v=1", InstD, PCPlus8D, ValidD); end
  endtask

  task automatic test_priority_drop();
    apply_reset(2);
    @(negedge clk);
    BranchTakenE = 1'b1; BranchTargetE = 32'h200;
    PCSrcW = 1'b1; ResultW = 32'h300;
    @(negedge clk);
    BranchTakenE = 1'b0; PCSrcW = 1'b0;
    #1;
    checks++; if (PCF !== 32'h200) begin failures++; $display("FAIL prio_pcf: got %h want 00000200", PCF); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL drop_noreq: got req=%b want 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || ValidD !== 1'b0) begin
      failures++; $display("FAIL drop_refetch: got req=%b addr=%h v=%b want req=1 addr=00000200 v=0", imem_req, imem_addr, ValidD); end
    PCSrcW = 1'b1; ResultW = 32'h303;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL pcsrc_noreq: got req=%b want 0", imem_req); end
    @(negedge clk);
    PCSrcW = 1'b0;
    #1;
    checks++; if (PCF !== 32'h300 || imem_addr !== 32'h300) begin
      failures++; $display("FAIL pcsrc_target: got pcf=%h addr=%h want 00000300", PCF, imem_addr); end
  endtask

  task automatic test_flush_latency();
    apply_reset(3);
    repeat (4) @(negedge clk);
    checks++; if (ValidD !== 1'b1 || InstD !== 32'h0 || PCPlus8D !== 32'h8) begin
      failures++; $display("FAIL lat_first: got v=%b inst=%h pc8=%h want v=1 inst=00000000 pc8=00000008", ValidD, InstD, PCPlus8D); end
    StallD = 1'b1; FlushD = 1'b1;
    @(negedge clk);
    StallD = 1'b0; FlushD = 1'b0;
    #1;
    checks++; if (ValidD !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL lat_flush: got v=%b req=%b want v=0 req=0", ValidD, imem_req); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (InstD !== 32'h4 || PCPlus8D !== 32'hC || ValidD !== 1'b1) begin
      failures++; $display("FAIL lat_after_flush: got inst=%h pc8=%h v=%b want inst=00000004 pc8=0000000c v=1", InstD, PCPlus8D, ValidD); end
    checks++; if (m_overlap !== 1'b0) begin failures++; $display("FAIL lat_single_outstanding: got overlap=%b want 0", m_overlap); end
  endtask

  task automatic test_wrap();
    apply_reset(1);
    BranchTakenE = 1'b1; BranchTargetE = 32'hFFFF_FFFC;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_noreq: got req=%b want 0", imem_req); end
    @(negedge clk);
    BranchTakenE = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_addr); end
    @(negedge clk);
    checks++; if (PCPlus8D !== 32'h4 || InstD !== 32'hFFFF_FFFC || PCF !== 32'h0) begin
      failures++; $display("FAIL wrap_ifid: got pc8=%h inst=%h pcf=%h want pc8=00000004 inst=fffffffc pcf=00000000", PCPlus8D, InstD, PCF); end
  endtask

  task automatic test_reset_mid();
    apply_reset(1);
    repeat (4) @(negedge clk);
    checks++; if (ValidD !== 1'b1 || PCF !== 32'hC) begin
      failures++; $display("FAIL rstmid_pre: got v=%b pcf=%h want v=1 pcf=0000000c", ValidD, PCF); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req_low: got %b want 0", imem_req); end
    @(negedge clk);
    checks++; if (PCF !== 32'h0 || ValidD !== 1'b0 || InstD !== 32'h0 || PCPlus8D !== 32'h0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL rstmid_state: got pcf=%h v=%b inst=%h pc8=%h req=%b want all zero", PCF, ValidD, InstD, PCPlus8D, imem_req); end
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL rstmid_restart: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_branch();
    test_priority_drop();
    test_flush_latency();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
